// File: rtl/gray_step_counter_pkg.sv
// rtl/gray_step_counter_pkg.sv - shared types and helpers for the Gray step counter
//
// Purpose: default counter width, debouncer state encoding and the
//          binary-to-Gray conversion used by gray_step_counter.
// Ports:   none (package).
package gray_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    STABLE_LO,
    CNT_HI,
    STABLE_HI,
    CNT_LO
  } deb_state_t;

  // Callers cast the result down to their own width; upper bits fall away.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_step_counter_if.sv
// rtl/gray_step_counter_if.sv - control and result bundle of the Gray step counter
//
// Purpose: groups the user controls and the count outputs of gray_step_counter.
// Signals: btn_step  raw step button (1 = pressed)
//          dir       count direction (1 = up, 0 = down)
//          auto_en   enable periodic self-advance
//          clear     hold the count at zero
//          gray_out  Gray code of bin_out
//          bin_out   binary count
//          step_pulse one-cycle strobe per count change
//          wrap      one-cycle strobe when a step wraps the count
// Modports: master drives the controls, slave (the counter) drives the results.
interface gray_step_counter_if
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             btn_step;
  logic             dir;
  logic             auto_en;
  logic             clear;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             step_pulse;
  logic             wrap;

  modport master (
    output btn_step, dir, auto_en, clear,
    input  gray_out, bin_out, step_pulse, wrap
  );

  modport slave (
    input  btn_step, dir, auto_en, clear,
    output gray_out, bin_out, step_pulse, wrap
  );
endinterface

// File: rtl/gray_step_counter_debouncer.sv
// rtl/gray_step_counter_debouncer.sv - button synchronizer, debouncer and press detector
//
// Purpose: brings a raw bouncing button into the clock domain, accepts a level
//          change only after DEBOUNCE_CYCLES consecutive differing samples and
//          flags each accepted press with a one-cycle event.
// Ports:   clock     system clock
//          reset     asynchronous active-low reset
//          raw       raw button input
//          level     debounced button level
//          rise_evt  one-cycle strobe after the debounced level rises
module button_debouncer
  import gray_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_evt
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_prev;
  deb_state_t    state;
  deb_state_t    state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  assign level = (state == STABLE_HI) || (state == CNT_LO);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      state      <= STABLE_LO;
      cnt        <= '0;
      level_prev <= 1'b0;
      rise_evt   <= 1'b0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      state      <= state_d;
      cnt        <= cnt_d;
      level_prev <= level;
      rise_evt   <= level & ~level_prev;
    end
  end

  // The counter holds the number of consecutive samples that differed from
  // the debounced level; the first differing sample already counts as one.
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    case (state)
      STABLE_LO: begin
        if (sync2) begin
          state_d = CNT_HI;
          cnt_d   = CW'(1);
        end
      end
      CNT_HI: begin
        if (!sync2)               state_d = STABLE_LO;
        else if (cnt == CNT_LAST) state_d = STABLE_HI;
        else                      cnt_d   = cnt + 1'b1;
      end
      STABLE_HI: begin
        if (!sync2) begin
          state_d = CNT_LO;
          cnt_d   = CW'(1);
        end
      end
      CNT_LO: begin
        if (sync2)                state_d = STABLE_HI;
        else if (cnt == CNT_LAST) state_d = STABLE_LO;
        else                      cnt_d   = cnt + 1'b1;
      end
      default: state_d = STABLE_LO;
    endcase
  end

endmodule

// File: rtl/gray_step_counter.sv
// rtl/gray_step_counter.sv - debounced / auto-advancing up-down counter with Gray output
//
// Purpose: steps a WIDTH-bit binary count on each debounced button press or
//          prescaled auto tick, and presents it registered in binary and Gray.
// Ports:   clock  system clock
//          reset  asynchronous active-low reset
//          bus    gray_step_counter_if.slave: btn_step, dir, auto_en, clear in;
//                 gray_out, bin_out, step_pulse, wrap out
module gray_step_counter
  import gray_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_DIV        = 50000000
) (
  input  logic                 clock,
  input  logic                 reset,
  gray_step_counter_if.slave   bus
);

  localparam int PW = $clog2(AUTO_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(AUTO_DIV - 1);

  logic             dir_s1, dir_s2;
  logic             auto_s1, auto_s2;
  logic             clr_s1, clr_s2;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             step_q;
  logic             wrap_q;
  logic             btn_level;
  logic             btn_evt;
  logic             tick;
  logic             step_req;
  logic [WIDTH-1:0] bin_next;
  logic             wrap_next;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock   (clock),
    .reset   (reset),
    .raw     (bus.btn_step),
    .level   (btn_level),
    .rise_evt(btn_evt)
  );

  assign tick      = auto_s2 && !clr_s2 && (presc == PRESC_LAST);
  // A press is honoured only while the debounced level is still high.
  assign step_req  = (btn_evt && btn_level) || tick;
  assign bin_next  = dir_s2 ? bin_q + 1'b1 : bin_q - 1'b1;
  assign wrap_next = dir_s2 ? (&bin_q) : ~(|bin_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dir_s1  <= 1'b0;
      dir_s2  <= 1'b0;
      auto_s1 <= 1'b0;
      auto_s2 <= 1'b0;
      clr_s1  <= 1'b0;
      clr_s2  <= 1'b0;
      presc   <= '0;
      bin_q   <= '0;
      gray_q  <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      dir_s1  <= bus.dir;
      dir_s2  <= dir_s1;
      auto_s1 <= bus.auto_en;
      auto_s2 <= auto_s1;
      clr_s1  <= bus.clear;
      clr_s2  <= clr_s1;

      if (!auto_s2 || clr_s2 || presc == PRESC_LAST) presc <= '0;
      else                                           presc <= presc + 1'b1;

      // Clear wins over any step and never raises a strobe.
      if (clr_s2) begin
        bin_q  <= '0;
        gray_q <= '0;
        step_q <= 1'b0;
        wrap_q <= 1'b0;
      end else if (step_req) begin
        bin_q  <= bin_next;
        gray_q <= WIDTH'(bin2gray(32'(bin_next)));
        step_q <= 1'b1;
        wrap_q <= wrap_next;
      end else begin
        step_q <= 1'b0;
        wrap_q <= 1'b0;
      end
    end
  end

  assign bus.bin_out    = bin_q;
  assign bus.gray_out   = gray_q;
  assign bus.step_pulse = step_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_gray_step_counter.sv
// tb/tb_gray_step_counter.sv - self-checking bench for gray_step_counter
module tb_gray_step_counter;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;
  localparam int DIV   = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  gray_step_counter_if #(.WIDTH(WIDTH)) bus ();

  gray_step_counter #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_DIV       (DIV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Reference model: inputs reach the logic two edges late; a button level
  // change is accepted on the DEB-th consecutive differing sample and a press
  // acts two edges after acceptance; the auto tick fires every DIV-th
  // consecutive enabled edge.
  int m_bin;
  bit m_sp, m_wr;
  bit b1, b2, d1, d2, a1, a2, c1, c2;
  bit lvl, e1, e2;
  int dr, en_run;

  task automatic model_step();
    bit evt, tk, en;
    if (!reset) begin
      m_bin = 0; m_sp = 0; m_wr = 0;
      b1 = 0; b2 = 0; d1 = 0; d2 = 0; a1 = 0; a2 = 0; c1 = 0; c2 = 0;
      lvl = 0; e1 = 0; e2 = 0; dr = 0; en_run = 0;
    end else begin
      evt = e2; e2 = e1; e1 = 0;
      en = a2 && !c2;
      tk = en && ((en_run % DIV) == DIV - 1);
      en_run = en ? en_run + 1 : 0;
      if (c2) begin
        m_bin = 0; m_sp = 0; m_wr = 0;
      end else if (evt || tk) begin
        m_wr  = d2 ? (m_bin == 255) : (m_bin == 0);
        m_bin = d2 ? (m_bin + 1) % 256 : (m_bin + 255) % 256;
        m_sp  = 1;
      end else begin
        m_sp = 0; m_wr = 0;
      end
      if (b2 != lvl) begin
        dr++;
        if (dr == DEB) begin
          lvl = !lvl;
          dr  = 0;
          if (lvl) e1 = 1;
        end
      end else begin
        dr = 0;
      end
      b2 = b1; b1 = bus.btn_step;
      d2 = d1; d1 = bus.dir;
      a2 = a1; a1 = bus.auto_en;
      c2 = c1; c1 = bus.clear;
    end
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    model_step();
  end

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  int steps = 0;
  int step_cyc[$];
  logic last_wrap = 1'b0;
  logic [WIDTH-1:0] prev_gray = '0;

  initial forever begin
    @(negedge clock);
    check_eq("bin", 32'(bus.bin_out), 32'(m_bin));
    check_eq("gray", 32'(bus.gray_out), 32'(m_bin ^ (m_bin >> 1)));
    check_eq("step", 32'(bus.step_pulse), 32'(m_sp));
    check_eq("wrap", 32'(bus.wrap), 32'(m_wr));
    if (bus.step_pulse === 1'b1) begin
      steps++;
      step_cyc.push_back(cyc);
      last_wrap = bus.wrap;
      check_eq("gray_onebit", 32'($countones(bus.gray_out ^ prev_gray)), 32'd1);
    end
    prev_gray = bus.gray_out;
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic press(input int hold);
    bus.btn_step = 1'b1;
    wait_cyc(hold);
    bus.btn_step = 1'b0;
    wait_cyc(hold);
  endtask

  task automatic zero_count();
    bus.clear = 1'b1;
    wait_cyc(4);
    bus.clear = 1'b0;
    wait_cyc(3);
  endtask

  initial begin
    int s0, n0, sv;
    logic [WIDTH-1:0] bv;
    logic [7:0] gseq [6];
    bit hit;

    gseq = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05};
    bus.btn_step = 1'b0;
    bus.dir      = 1'b0;
    bus.auto_en  = 1'b0;
    bus.clear    = 1'b0;

    // 1: reset state, single clean press, latency, held button
    wait_cyc(3);
    check_eq("rst_bin", 32'(bus.bin_out), 0);
    check_eq("rst_gray", 32'(bus.gray_out), 0);
    check_eq("rst_step", 32'(bus.step_pulse), 0);
    check_eq("rst_wrap", 32'(bus.wrap), 0);
    reset   = 1'b1;
    bus.dir = 1'b1;
    wait_cyc(3);
    s0 = steps;
    bus.btn_step = 1'b1;
    wait_cyc(7);
    check_eq("s1_early_bin", 32'(bus.bin_out), 0);
    wait_cyc(1);
    check_eq("s1_bin", 32'(bus.bin_out), 1);
    check_eq("s1_gray", 32'(bus.gray_out), 32'h01);
    check_eq("s1_step", 32'(bus.step_pulse), 1);
    wait_cyc(1);
    check_eq("s1_step_off", 32'(bus.step_pulse), 0);
    wait_cyc(10);
    check_eq("s1_held_bin", 32'(bus.bin_out), 1);
    check_eq("s1_held_steps", 32'(steps - s0), 1);
    bus.btn_step = 1'b0;
    wait_cyc(10);

    // 2: bouncing press and release
    s0 = steps;
    for (int i = 0; i < 10; i++) begin
      bus.btn_step = ~bus.btn_step;
      wait_cyc(2);
    end
    wait_cyc(1);
    check_eq("s2_bounce", 32'(steps - s0), 0);
    bus.btn_step = 1'b1;
    wait_cyc(12);
    check_eq("s2_press", 32'(steps - s0), 1);
    for (int i = 0; i < 10; i++) begin
      bus.btn_step = ~bus.btn_step;
      wait_cyc(2);
    end
    bus.btn_step = 1'b0;
    wait_cyc(12);
    check_eq("s2_release", 32'(steps - s0), 1);

    // 3: Gray sequence counting up from zero
    zero_count();
    check_eq("s3_zero", 32'(bus.bin_out), 0);
    for (int i = 0; i < 6; i++) begin
      press(8);
      check_eq("s3_gray", 32'(bus.gray_out), 32'(gseq[i]));
      check_eq("s3_bin", 32'(bus.bin_out), 32'(i + 1));
    end
    check_eq("s3_nowrap", 32'(last_wrap), 0);

    // 4: wrap down then up
    zero_count();
    bus.dir = 1'b0;
    s0 = steps;
    press(8);
    check_eq("s4_dn_bin", 32'(bus.bin_out), 32'hFF);
    check_eq("s4_dn_gray", 32'(bus.gray_out), 32'h80);
    check_eq("s4_dn_wrap", 32'(last_wrap), 1);
    check_eq("s4_dn_steps", 32'(steps - s0), 1);
    bus.dir = 1'b1;
    press(8);
    check_eq("s4_up_bin", 32'(bus.bin_out), 0);
    check_eq("s4_up_gray", 32'(bus.gray_out), 0);
    check_eq("s4_up_wrap", 32'(last_wrap), 1);

    // 5: auto advance, then a press landing on a tick
    s0 = steps;
    n0 = step_cyc.size();
    bus.auto_en = 1'b1;
    wait_cyc(40);
    bus.auto_en = 1'b0;
    wait_cyc(6);
    check_eq("s5_auto_steps", 32'(steps - s0), 5);
    if (step_cyc.size() >= n0 + 5) begin
      for (int i = 1; i < 5; i++)
        check_eq("s5_gap", 32'(step_cyc[n0 + i] - step_cyc[n0 + i - 1]), 8);
    end
    wait_cyc(4);
    bus.auto_en = 1'b1;
    wait_cyc(10);
    bus.btn_step = 1'b1;
    wait_cyc(7);
    bv = bus.bin_out;
    wait_cyc(1);
    check_eq("s5_coinc_bin", 32'(bus.bin_out), 32'(8'(bv + 8'd1)));
    check_eq("s5_coinc_step", 32'(bus.step_pulse), 1);
    bus.auto_en  = 1'b0;
    bus.btn_step = 1'b0;
    wait_cyc(12);

    // 6: clear at 0x2A, then reset during a debounce count
    zero_count();
    bus.auto_en = 1'b1;
    hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      wait_cyc(1);
      if (bus.bin_out == 8'h2A) hit = 1;
    end
    bus.auto_en = 1'b0;
    check_eq("s6_reach", 32'(bus.bin_out), 32'h2A);
    wait_cyc(4);
    s0 = steps;
    bus.clear = 1'b1;
    wait_cyc(4);
    check_eq("s6_clr_bin", 32'(bus.bin_out), 0);
    check_eq("s6_clr_gray", 32'(bus.gray_out), 0);
    press(12);
    check_eq("s6_clr_steps", 32'(steps - s0), 0);
    check_eq("s6_clr_hold", 32'(bus.bin_out), 0);
    bus.clear = 1'b0;
    wait_cyc(4);
    press(8);
    check_eq("s6_pre_rst", 32'(bus.bin_out), 1);
    s0 = steps;
    bus.btn_step = 1'b1;
    wait_cyc(4);
    reset = 1'b0;
    bus.btn_step = 1'b0;
    #1;
    check_eq("s6_rst_bin", 32'(bus.bin_out), 0);
    check_eq("s6_rst_gray", 32'(bus.gray_out), 0);
    wait_cyc(1);
    reset = 1'b1;
    wait_cyc(15);
    check_eq("s6_no_step", 32'(steps - s0), 0);
    check_eq("s6_after_bin", 32'(bus.bin_out), 0);

    // randomized run against the model
    for (int i = 0; i < 250; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        reset = 1'b0;
        wait_cyc(1);
        reset = 1'b1;
      end else if (r < 10) begin
        bus.clear = ($urandom_range(0, 3) == 0);
      end else if (r < 25) begin
        bus.auto_en = 1'($urandom_range(0, 1));
      end else if (r < 40) begin
        bus.dir = 1'($urandom_range(0, 1));
      end else begin
        bus.btn_step = 1'($urandom_range(0, 1));
      end
      wait_cyc(int'($urandom_range(1, 12)));
    end
    bus.clear   = 1'b0;
    bus.auto_en = 1'b0;
    wait_cyc(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
